coin_acceptor: RTL and testbench

//  Front end of the vending machine coin path. Synchronises and debounces the raw quarter
//  and dollar sensors and queues accepted coins in a small FIFO. Replays each queued coin
//  as one clean, spaced pulse on coin1 (25c) or coin2 (100c), which feed the vending

---
 rtl/coin_acceptor.sv | 234 +++++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounced quarter/dollar sensors, coin FIFO, spaced pulse replay.
// Define COIN_TALLY_EN to add the saturating tally_q/tally_d accepted-coin counters.
module coin_acceptor #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int PULSE_HI     = 2,
    parameter int PULSE_GAP    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        coin_q_raw,
    input  logic                        coin_d_raw,
    output logic                        coin1,
    output logic                        coin2,
    output logic                        reject,
    output logic                        busy,
`ifdef COIN_TALLY_EN
    output logic [7:0]                  tally_q,
    output logic [7:0]                  tally_d,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int PMAX = (PULSE_HI > PULSE_GAP) ? PULSE_HI : PULSE_GAP;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // Input stage: bit 0 = quarter sensor, bit 1 = dollar sensor
    // ---------------------------------------------------------------
    logic [1:0]    raw;
    logic [1:0]    s1_q;
    logic [1:0]    s2_q;
    logic [1:0]    lvl_q;
    logic [1:0]    lvl_d;
    logic [1:0]    ev_q;
    logic [1:0]    ev_d;
    logic [CW-1:0] dbc_q [2];
    logic [CW-1:0] dbc_d [2];

    assign raw = {coin_d_raw, coin_q_raw};

    // Debounce: count cycles the synced value disagrees with the accepted level
    always_comb begin
        lvl_d = lvl_q;
        ev_d  = '0;
        for (int i = 0; i < 2; i++) begin
            dbc_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (dbc_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
                    lvl_d[i] = s2_q[i];
                    ev_d[i]  = s2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + CW'(1);
                end
            end
        end
    end

    // Two-flop synchronisers, debounced levels and registered coin events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            lvl_q <= '0;
            ev_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            ev_q  <= ev_d;
            for (int i = 0; i < 2; i++) begin
                dbc_q[i] <= dbc_d[i];
            end
        end
    end

    // ---------------------------------------------------------------
    // Coin FIFO: 1-bit entries, 0 = quarter, 1 = dollar
    // ---------------------------------------------------------------
    logic [FIFO_DEPTH-1:0] mem_q;
    logic [FIFO_DEPTH-1:0] mem_d;
    logic [LW-1:0]         wptr_q;
    logic [LW-1:0]         wptr_d;
    logic [LW-1:0]         wptr2;
    logic [LW-1:0]         rptr_q;
    logic [LW-1:0]         rptr_d;
    logic [LW-1:0]         level;
    logic [LW-1:0]         occ;
    logic [LW-1:0]         free;
    logic                  pop;
    logic                  acc_q;
    logic                  acc_d;
    logic                  drop;
    logic                  reject_q;

    assign level = wptr_q - rptr_q;

    // Push up to two events, quarter first; a same-cycle pop frees a slot
    always_comb begin
        occ   = level - LW'(pop);
        free  = LW'(FIFO_DEPTH) - occ;
        acc_q = ev_q[0] && (free != '0);
        acc_d = ev_q[1] && (free > (acc_q ? LW'(1) : LW'(0)));
        drop  = (ev_q[0] && !acc_q) || (ev_q[1] && !acc_d);
        wptr2 = wptr_q + LW'(acc_q);
        mem_d = mem_q;
        if (acc_q) begin
            mem_d[wptr_q[AW-1:0]] = 1'b0;
        end
        if (acc_d) begin
            mem_d[wptr2[AW-1:0]] = 1'b1;
        end
        wptr_d = wptr2 + LW'(acc_d);
        rptr_d = rptr_q + LW'(pop);
    end

    // FIFO storage, pointers and the one-cycle reject flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            reject_q <= drop;
        end
    end

    // ---------------------------------------------------------------
    // Output pulse FSM
    // ---------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          typ_q;
    logic          typ_d;

    // Next state: pop in IDLE, hold HIGH then GAP for their cycle counts
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        typ_d   = typ_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    typ_d   = mem_q[rptr_q[AW-1:0]];
                    pcnt_d  = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (pcnt_q == PW'(PULSE_HI - 1)) begin
                    pcnt_d  = '0;
                    state_d = GAP;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            GAP: begin
                if (pcnt_q == PW'(PULSE_GAP - 1)) begin
                    pcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    // FSM state, phase counter and latched coin type
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            typ_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            typ_q   <= typ_d;
        end
    end

    assign coin1      = (state_q == HIGH) && !typ_q;
    assign coin2      = (state_q == HIGH) && typ_q;
    assign reject     = reject_q;
    assign busy       = (level != '0) || (state_q != IDLE);
    assign fifo_level = level;

`ifdef COIN_TALLY_EN
    logic [7:0] tq_q;
    logic [7:0] td_q;

    // Saturating counts of coins actually accepted into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tq_q <= '0;
            td_q <= '0;
        end else begin
            if (acc_q && (tq_q != 8'hFF)) begin
                tq_q <= tq_q + 8'd1;
            end
            if (acc_d && (td_q != 8'hFF)) begin
                td_q <= td_q + 8'd1;
            end
        end
    end

    assign tally_q = tq_q;
    assign tally_d = td_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: scoreboard bench for coin_acceptor.
// u_dut uses default timing; u_slow has long pulses so its FIFO can fill.
`timescale 1ns/1ps
module tb_coin_acceptor;

    localparam int LW = $clog2(4) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          q_raw = 1'b0;
    logic          d_raw = 1'b0;
    logic          c1, c2, rej, bsy;
    logic [LW-1:0] lvl;
    logic          s_c1, s_c2, s_rej, s_bsy;
    logic [LW-1:0] s_lvl;
`ifdef COIN_TALLY_EN
    logic [7:0]    tq, td, s_tq, s_td;
`endif

    coin_acceptor u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_q_raw (q_raw),
        .coin_d_raw (d_raw),
        .coin1      (c1),
        .coin2      (c2),
        .reject     (rej),
        .busy       (bsy),
`ifdef COIN_TALLY_EN
        .tally_q    (tq),
        .tally_d    (td),
`endif
        .fifo_level (lvl)
    );

    coin_acceptor #(
        .PULSE_HI  (30),
        .PULSE_GAP (10)
    ) u_slow (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_q_raw (q_raw),
        .coin_d_raw (d_raw),
        .coin1      (s_c1),
        .coin2      (s_c2),
        .reject     (s_rej),
        .busy       (s_bsy),
`ifdef COIN_TALLY_EN
        .tally_q    (s_tq),
        .tally_d    (s_td),
`endif
        .fifo_level (s_lvl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit typ;
        int abs_s;
        int rel_s;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   sb_en   = 1'b1;

    // monitor-private state
    exp_t cur_exp;
    chk_t cur_chk;
    bit   p1 = 1'b0;
    bit   p2 = 1'b0;
    bit   in_pulse = 1'b0;
    bit   cur_typ = 1'b0;
    int   st = 0;
    int   last_rise = 0;

    function automatic void compare(string n, int a, int e);
        n_total++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", n, a, e);
    endfunction

    // Monitor: compares queued status checks and every coin pulse
    initial begin
        forever begin
            @(negedge clk);
            while (chk_q.size() != 0) begin
                cur_chk = chk_q.pop_front();
                compare(cur_chk.name, cur_chk.act, cur_chk.exp);
            end
            if (!sb_en) begin
                in_pulse = 1'b0;
            end else if ((c1 || c2) && !(p1 || p2)) begin
                compare("overlap", int'(c1 && c2), 0);
                compare("pulse_expected", int'(exp_q.size() > 0), 1);
                st       = cyc;
                cur_typ  = c2;
                in_pulse = 1'b1;
            end else if (!(c1 || c2) && in_pulse) begin
                in_pulse = 1'b0;
                if (exp_q.size() != 0) begin
                    cur_exp = exp_q.pop_front();
                    compare("coin_type", int'(cur_typ), int'(cur_exp.typ));
                    compare("pulse_width", cyc - st, 2);
                    if (cur_exp.abs_s >= 0)
                        compare("rise_cycle", st, cur_exp.abs_s);
                    if (cur_exp.rel_s >= 0)
                        compare("rise_spacing", st - last_rise, cur_exp.rel_s);
                end
                last_rise = st;
            end
            p1 = c1;
            p2 = c2;
        end
    end

    // stimulus-side sampling
    int pk_def    = 0;
    int pk_slow   = 0;
    int rej_def   = 0;
    int rej_slow  = 0;
    int rise_slow = 0;
    bit ps1       = 1'b0;

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            if (int'(lvl) > pk_def) pk_def = int'(lvl);
            if (int'(s_lvl) > pk_slow) pk_slow = int'(s_lvl);
            if (rej) rej_def++;
            if (s_rej) rej_slow++;
            if (s_c1 && !ps1) rise_slow++;
            ps1 = s_c1;
        end
    endtask

    task automatic chk(string n, int a, int e);
        chk_q.push_back('{name: n, act: a, exp: e});
    endtask

    task automatic sb_push(bit d, int abs_s, int rel_s);
        exp_q.push_back('{typ: d, abs_s: abs_s, rel_s: rel_s});
    endtask

    task automatic coin(bit d, int hi, int lo);
        if (d) d_raw = 1'b1;
        else q_raw = 1'b1;
        tick(hi);
        if (d) d_raw = 1'b0;
        else q_raw = 1'b0;
        tick(lo);
    endtask

    task automatic drain(int lim, string n);
        int k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            tick(1);
            k++;
        end
        chk(n, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin
        int k;
        // reset state
        tick(3);
        chk("rst_coin1", int'(c1), 0);
        chk("rst_coin2", int'(c2), 0);
        chk("rst_reject", int'(rej), 0);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_level", int'(lvl), 0);
        rst_n = 1'b1;
        tick(3);

        // clean quarter: rise 8 edges after the first sampling edge
        sb_push(1'b0, cyc + 8, -1);
        coin(1'b0, 20, 12);
        drain(50, "t1_drain");
        tick(5);
        chk("t1_busy", int'(bsy), 0);
        chk("t1_level", int'(lvl), 0);

        // bouncing dollar gives one pulse; 3-cycle quarter glitch none
        sb_push(1'b1, -1, -1);
        for (int i = 0; i < 3; i++) begin
            d_raw = 1'b1;
            tick(2);
            d_raw = 1'b0;
            tick(2);
        end
        coin(1'b1, 10, 10);
        coin(1'b0, 3, 12);
        drain(40, "t2_drain");
        tick(20);
        chk("t2_busy", int'(bsy), 0);

        // simultaneous coins: quarter first, dollar 5 cycles later
        pk_def = 0;
        sb_push(1'b0, cyc + 8, -1);
        sb_push(1'b1, -1, 5);
        q_raw = 1'b1;
        d_raw = 1'b1;
        tick(6);
        q_raw = 1'b0;
        d_raw = 1'b0;
        tick(10);
        drain(40, "t3_drain");
        chk("t3_level_peak", pk_def, 2);
        chk("t3_no_reject", rej_def, 0);

        // overflow: six quarters, slow instance keeps only four queued
        do_reset();
        pk_slow   = 0;
        rej_slow  = 0;
        rise_slow = 0;
        for (int i = 0; i < 6; i++) begin
            sb_push(1'b0, -1, (i == 0) ? -1 : 8);
            coin(1'b0, 4, 4);
        end
        drain(40, "t4_drain");
        k = 0;
        while (s_bsy && k < 400) begin
            tick(1);
            k++;
        end
        chk("t4_slow_busy", int'(s_bsy), 0);
        chk("t4_slow_reject", rej_slow, 1);
        chk("t4_slow_pulses", rise_slow, 5);
        chk("t4_slow_peak", pk_slow, 4);
        chk("t4_def_reject", rej_def, 0);

        // reset during HIGH with three queued
        do_reset();
        sb_en = 1'b0;
        for (int i = 0; i < 4; i++) coin(1'b0, 4, 4);
        tick(1);
        chk("t5_pre_level", int'(s_lvl), 3);
        chk("t5_pre_coin1", int'(s_c1), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_coin1", int'(s_c1), 0);
        chk("t5_level", int'(s_lvl), 0);
        chk("t5_busy", int'(s_bsy), 0);
        chk("t5_def_level", int'(lvl), 0);
        tick(3);
        rst_n = 1'b1;
        exp_q.delete();
        tick(1);
        rise_slow = 0;
        sb_en = 1'b1;
        tick(100);
        chk("t5_no_pulses", rise_slow, 0);
        chk("t5_def_busy", int'(bsy), 0);

`ifdef COIN_TALLY_EN
        // tallies count accepted coins and saturate
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sb_push(1'b0, -1, -1);
            coin(1'b0, 4, 4);
        end
        for (int i = 0; i < 2; i++) begin
            sb_push(1'b1, -1, -1);
            coin(1'b1, 4, 4);
        end
        drain(60, "t6_drain");
        chk("t6_tally_q", int'(tq), 3);
        chk("t6_tally_d", int'(td), 2);
        for (int i = 0; i < 300; i++) begin
            sb_push(1'b0, -1, -1);
            coin(1'b0, 4, 4);
        end
        drain(60, "t6_sat_drain");
        chk("t6_tally_q_sat", int'(tq), 255);
        chk("t6_tally_d_hold", int'(td), 2);
`endif

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
